// File: rtl/ifetch_queue_pkg.sv
// Shared core types for the fetch/decode boundary; XLEN comes from the core params header.
`ifndef XLEN
`define XLEN 32
`endif

package ifetch_queue_pkg;

  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic [31:0]      instr;
    logic             fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode, no bypass,
// flush on redirect, asynchronous active-low reset of the pointers only.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [`XLEN-1:0]         in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [`XLEN-1:0]         out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t mem [DEPTH];
  fetch_entry_t entry_in;
  fetch_entry_t entry_out;

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_nxt, rd_nxt;
  logic        full, empty, push, pop;

  // Extra pointer MSB tells full from empty when the indexes coincide.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid & in_ready & !flush;
  assign pop  = out_valid & out_ready & !flush;

  assign entry_in = '{pc: in_pc, instr: in_instr, fault: in_fault};

  always_comb begin
    wr_nxt = wr_ptr + {{AW{1'b0}}, push};
    rd_nxt = rd_ptr + {{AW{1'b0}}, pop};
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
    end
  end

  // Storage is never reset; contents are don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= entry_in;
    end
  end

  assign entry_out = mem[rd_ptr[AW-1:0]];
  assign out_pc    = entry_out.pc;
  assign out_instr = entry_out.instr;
  assign out_fault = entry_out.fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, single push, fill/drain, wrap under
// simultaneous push/pop, flush, fault pass-through and asynchronous reset.
`ifndef XLEN
`define XLEN 32
`endif

module tb_ifetch_queue;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [`XLEN-1:0]   in_pc;
  logic [31:0]        in_instr;
  logic               in_fault;
  logic               out_valid;
  logic               out_ready;
  logic [`XLEN-1:0]   out_pc;
  logic [31:0]        out_instr;
  logic               out_fault;
  logic [2:0]         count;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_fault  (in_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_fault (out_fault),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [`XLEN-1:0] exp_pop [8];

  initial begin
    exp_pop = '{32'h2000, 32'h2004, 32'h2008, 32'h200C,
                32'h3004, 32'h3008, 32'h300C, 32'h3010};
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_instr = '0; in_fault = 1'b0; out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b1;
    step();

    // Single push with decode stalled
    in_valid = 1'b1; in_pc = 32'h1000; in_instr = 32'h00A00513; in_fault = 1'b0;
    step();
    in_valid = 1'b0;
    chk("push1_valid", out_valid, 1);
    chk("push1_count", count, 1);
    chk("push1_pc", out_pc, 32'h1000);
    chk("push1_instr", out_instr, 32'h00A00513);
    chk("push1_fault", out_fault, 0);
    step();
    chk("hold_pc", out_pc, 32'h1000);
    chk("hold_instr", out_instr, 32'h00A00513);
    chk("hold_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop1_valid", out_valid, 0);
    chk("pop1_count", count, 0);

    // Fill to full, refused fifth offer, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4*i); in_instr = 32'h13 + 32'(i);
      step();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    in_pc = 32'h1010;
    step();
    in_valid = 1'b0;
    chk("full5_count", count, 4);
    chk("full5_head", out_pc, 32'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_pc", out_pc, 32'h1000 + 32'(4*i));
      step();
    end
    out_ready = 1'b0;
    chk("drained_valid", out_valid, 0);
    chk("drained_count", count, 0);

    // Refill, then streaming push/pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h2000 + 32'(4*i);
      step();
    end
    chk("refill_count", count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_pc = 32'h3000 + 32'(4*k);
      chk("stream_in_ready", in_ready, (k == 0) ? 1'b0 : 1'b1);
      chk("stream_pc", out_pc, exp_pop[k]);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_count", count, 3);
    chk("stream_head", out_pc, 32'h3014);

    // Flush with a concurrent offer at count 3
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    step();
    chk("flush_dropped", out_valid, 0);

    // Fault passes through with its entry
    in_valid = 1'b1; in_pc = 32'h1002; in_instr = 32'h0; in_fault = 1'b1;
    step();
    chk("fault_bit", out_fault, 1);
    chk("fault_pc", out_pc, 32'h1002);
    chk("fault_count", count, 1);
    in_pc = 32'h1006; in_fault = 1'b0;
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", count, 2);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 1);
    #2;
    rst = 1'b1;
    step();
    in_valid = 1'b1; in_pc = 32'h5000; in_fault = 1'b0;
    step();
    in_valid = 1'b0;
    chk("cold_pc", out_pc, 32'h5000);
    chk("cold_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-002 SHALL take data width `XLEN from the shared core params header, not as a parameter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  redirect; discard all queued and incoming entries.
REQ-006 SHALL have port in_valid  input  1  fetch offers an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts the entry.
REQ-008 SHALL have port in_pc  input  `XLEN  instruction address.
REQ-009 SHALL have port in_instr  input  32  instruction word.
REQ-010 SHALL have port in_fault  input  1  fetch fault (bus error or misaligned) for this entry.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port out_ready  input  1  decode consumes the head entry.
REQ-013 SHALL have ports out_pc  output  `XLEN, out_instr  output  32, and out_fault  output  1, carrying the head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL implement a circular buffer with read and write pointers one bit wider than the index; full when the indexes match and the MSBs differ, empty when the pointers are equal; pointers wrap modulo 2*DEPTH.
REQ-016 SHALL perform a push on a rising edge when in_valid & in_ready & !flush.
REQ-017 SHALL perform a pop on a rising edge when out_valid & out_ready & !flush.
REQ-018 SHALL drive in_ready = !full only; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-019 SHALL drive out_valid = !empty and take out_* from the storage entry at the read pointer; there SHALL be no bypass, so latency is one cycle from push to out_valid.
REQ-020 SHALL hold out_pc, out_instr and out_fault stable while out_valid & !out_ready.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and move both pointers; when full, in_ready=0 that cycle, so no push occurs.
REQ-022 SHALL, when flush=1 on an edge, set both pointers to 0 and count to 0, ignore any push or pop that cycle, and deassert out_valid from the next cycle.
REQ-023 SHALL resume accepting pushes on the cycle after flush deasserts; in_ready SHALL be 1 then.
REQ-024 SHALL keep count equal to write pointer minus read pointer (modulo 2*DEPTH), registered, so count is never greater than DEPTH.
REQ-025 SHALL pass in_fault through unmodified with its entry; the queue SHALL NOT interpret instr or pc.
REQ-026 SHALL treat simulation-only assertions as errors: push while full, pop while empty, count greater than DEPTH.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear the pointers, giving count=0, out_valid=0 and in_ready=1.
REQ-028 SHALL NOT need to reset the storage array; out_pc, out_instr and out_fault are don't-care while out_valid=0.
REQ-029 SHALL, on reset asserted mid-transfer, drop all entries; after release, behaviour SHALL match a cold start.

Structure
REQ-030 SHALL take the typedef fetch_entry_t {pc, instr, fault} from the shared core package, reused by fetch and decode.
REQ-031 SHALL be a single module with no sub-module; pointer logic is too small to factor out.

Verification
REQ-032 SHALL cover: push pc=h1000 instr=h00A00513 fault=0 with out_ready=0 -> out_valid=1 and the same values on the next cycle, count=1.
REQ-033 SHALL cover: push 4 entries with out_ready=0 and DEPTH=4 -> in_ready=0, count=4; a 5th offer is not accepted; then drain, getting pcs h1000, h1004, h1008, h100C in order.
REQ-034 SHALL cover: at count=4 drive out_ready=1 and in_valid=1 for 8 cycles -> pops each cycle; a push is accepted only once in_ready returns, with no loss or duplication across pointer wrap.
REQ-035 SHALL cover: count=3 with flush=1 and in_valid=1 on the same edge -> count=0 and out_valid=0 next cycle; the offered entry is dropped.
REQ-036 SHALL cover: push pc=h1002 fault=1 -> out_fault=1 with out_pc=h1002.
REQ-037 SHALL cover: rst=0 asynchronously mid-stream at count=2 -> out_valid=0 and count=0 immediately, before the next edge.
